rtc_bus_cycle: RTL

- Downstream stage of the RTC write/read sequencer FSMs.
- Executes one complete multiplexed address/data bus transaction on the RTC chip pins per request: address phase, then data phase, as write or read.
- Once started, a transaction always runs to completion. A sequencer dropping its request, or jumping back to its idle state, never truncates a cycle in flight.

---
 rtl/rtc_pkg.sv | 53 +++++
 rtl/rtc_bus_cycle_if.sv | 71 +++++++
 rtl/rtc_bus_cycle.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
//
// Purpose:
//   Definitions shared by the RTC write/read sequencers and by the bus-cycle
//   engine underneath them:
//     - FSM state encoding of the bus-cycle engine
//     - register addresses of the RTC chip
//     - a small constant helper used to size the phase counter
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package rtc_pkg;

    // -----------------------------------------------------------------------
    // Bus-cycle FSM state encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_ADDR_ENC = 3'd1;
    localparam logic [2:0] ST_GAP1_ENC = 3'd2;
    localparam logic [2:0] ST_DATA_ENC = 3'd3;
    localparam logic [2:0] ST_GAP2_ENC = 3'd4;
    localparam logic [2:0] ST_DONE_ENC = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_ADDR = ST_ADDR_ENC,
        ST_GAP1 = ST_GAP1_ENC,
        ST_DATA = ST_DATA_ENC,
        ST_GAP2 = ST_GAP2_ENC,
        ST_DONE = ST_DONE_ENC
    } bus_state_t;

    // -----------------------------------------------------------------------
    // RTC chip register map
    // -----------------------------------------------------------------------
    localparam logic [7:0] RTC_CMD     = 8'hF0;
    localparam logic [7:0] RTC_SEG     = 8'h21;
    localparam logic [7:0] RTC_MIN     = 8'h22;
    localparam logic [7:0] RTC_HORA    = 8'h23;
    localparam logic [7:0] RTC_DIA     = 8'h24;
    localparam logic [7:0] RTC_MES     = 8'h25;
    localparam logic [7:0] RTC_ANIO    = 8'h26;
    localparam logic [7:0] RTC_SEG_TIM = 8'h41;
    localparam logic [7:0] RTC_MIN_TIM = 8'h42;
    localparam logic [7:0] RTC_HORA_TIM = 8'h43;

    // Larger of two integers; used at elaboration time to size counters.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rtc_bus_cycle_if.sv
// ---------------------------------------------------------------------------
// rtc_bus_cycle_if
//
// Purpose:
//   Groups the request side (sequencer -> bus-cycle engine) and the RTC pin
//   side (engine <-> pads) of one multiplexed address/data bus engine.
//
// Signals:
//   start, rnw, addr, wdata : transaction request from the sequencer
//   ad_in                   : AD bus value coming back from the pad
//   ad_out, ad_oe           : AD bus drive value and output enable
//   a_d, cs, rd, wr         : RTC control pins (cs/rd/wr active-low)
//   rdata                   : last captured read data
//   busy, done              : engine status, done is a one-cycle pulse
//
// Modports:
//   master : sequencer / pad side (drives request and ad_in)
//   slave  : the bus-cycle engine
// ---------------------------------------------------------------------------
interface rtc_bus_cycle_if;

    logic       start;
    logic       rnw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [7:0] rdata;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output rnw,
        output addr,
        output wdata,
        output ad_in,
        input  ad_out,
        input  ad_oe,
        input  a_d,
        input  cs,
        input  rd,
        input  wr,
        input  rdata,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  rnw,
        input  addr,
        input  wdata,
        input  ad_in,
        output ad_out,
        output ad_oe,
        output a_d,
        output cs,
        output rd,
        output wr,
        output rdata,
        output busy,
        output done
    );

endinterface

// File: rtl/rtc_bus_cycle.sv
// ---------------------------------------------------------------------------
// rtc_bus_cycle
//
// Purpose:
//   Runs one complete multiplexed address/data transaction on the RTC chip
//   pins per accepted request:
//       ADDR (T_STROBE) -> GAP1 (T_GAP) -> DATA (T_STROBE) -> GAP2 (T_GAP)
//       -> DONE (1) -> IDLE
//   The request (rnw/addr/wdata) is latched when start is accepted in IDLE;
//   afterwards the request inputs are ignored until the engine is idle again,
//   so a sequencer dropping or changing its request never truncates a cycle.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high; aborts any transaction immediately
//   bus    : rtc_bus_cycle_if.slave (request inputs, pin outputs, status)
//
// Parameters:
//   T_STROBE : cycles each strobe phase (address, data) is held, >= 1
//   T_GAP    : cycles of all-strobes-inactive after each phase, >= 1
//
// Every output is a flop. Next-cycle pin values are decoded from the next
// state, so pins change on the same edge as the state register and there is
// no combinational path from any input to a pin. The AD tristate itself
// (ad_oe ? ad_out : 'z) lives at pad level.
// ---------------------------------------------------------------------------
module rtc_bus_cycle
    import rtc_pkg::*;
#(
    parameter int T_STROBE = 4,
    parameter int T_GAP    = 3
) (
    input  logic           clk,
    input  logic           reset,
    rtc_bus_cycle_if.slave bus
);

    // One shared phase counter covers both strobe and gap phases.
    localparam int CNT_W = $clog2(max_int(T_STROBE, T_GAP)) + 1;

    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // -----------------------------------------------------------------------
    // State, counter and latched request
    // -----------------------------------------------------------------------
    bus_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rnw;
    logic [7:0]       r_addr;
    logic [7:0]       r_wdata;

    // Registered pins / status
    logic [7:0]       r_ad_out;
    logic             r_ad_oe;
    logic             r_a_d;
    logic             r_cs;
    logic             r_rd;
    logic             r_wr;
    logic [7:0]       r_rdata;
    logic             r_busy;
    logic             r_done;

    // -----------------------------------------------------------------------
    // Next-state / next-output decode
    // -----------------------------------------------------------------------
    bus_state_t       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_latch;
    logic             w_capture;

    // Request fields as they will be after this edge: on the accepting edge
    // the latch registers are still stale, so take the live inputs instead.
    logic             w_rnw_eff;
    logic [7:0]       w_addr_eff;
    logic [7:0]       w_wdata_eff;

    logic [7:0]       w_ad_out_next;
    logic             w_ad_oe_next;
    logic             w_a_d_next;
    logic             w_cs_next;
    logic             w_rd_next;
    logic             w_wr_next;
    logic             w_busy_next;
    logic             w_done_next;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        w_capture    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_ADDR;
                    w_cnt_next   = '0;
                    w_latch      = 1'b1;
                end
            end

            ST_ADDR: begin
                if (r_cnt == STROBE_LAST) begin
                    w_state_next = ST_GAP1;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end

            ST_GAP1: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_next = ST_DATA;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (r_cnt == STROBE_LAST) begin
                    w_state_next = ST_GAP2;
                    w_cnt_next   = '0;
                    // Sample the pad on the edge that closes the read strobe,
                    // giving the chip the full strobe width to drive AD.
                    w_capture    = r_rnw;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end

            ST_GAP2: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_next = ST_DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end

            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        w_rnw_eff   = w_latch ? bus.rnw   : r_rnw;
        w_addr_eff  = w_latch ? bus.addr  : r_addr;
        w_wdata_eff = w_latch ? bus.wdata : r_wdata;

        // Pin defaults: everything released, AD keeps its last value.
        w_ad_out_next = r_ad_out;
        w_ad_oe_next  = 1'b0;
        w_a_d_next    = 1'b1;
        w_cs_next     = 1'b1;
        w_rd_next     = 1'b1;
        w_wr_next     = 1'b1;
        w_busy_next   = (w_state_next != ST_IDLE);
        w_done_next   = 1'b0;

        case (w_state_next)
            ST_ADDR: begin
                w_a_d_next    = 1'b0;
                w_cs_next     = 1'b0;
                w_wr_next     = 1'b0;
                w_ad_out_next = w_addr_eff;
                w_ad_oe_next  = 1'b1;
            end

            ST_GAP1: begin
                // Bus released but the address value is held on ad_out.
                w_ad_out_next = w_addr_eff;
            end

            ST_DATA: begin
                w_cs_next = 1'b0;
                if (w_rnw_eff) begin
                    // Chip drives AD while rd is low, so never enable ours.
                    w_rd_next    = 1'b0;
                end else begin
                    w_wr_next     = 1'b0;
                    w_ad_out_next = w_wdata_eff;
                    w_ad_oe_next  = 1'b1;
                end
            end

            ST_DONE: begin
                w_done_next = 1'b1;
            end

            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rnw    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ad_out <= '0;
            r_ad_oe  <= 1'b0;
            r_a_d    <= 1'b1;
            r_cs     <= 1'b1;
            r_rd     <= 1'b1;
            r_wr     <= 1'b1;
            r_rdata  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            if (w_latch) begin
                r_rnw   <= bus.rnw;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end
            r_ad_out <= w_ad_out_next;
            r_ad_oe  <= w_ad_oe_next;
            r_a_d    <= w_a_d_next;
            r_cs     <= w_cs_next;
            r_rd     <= w_rd_next;
            r_wr     <= w_wr_next;
            if (w_capture) begin
                r_rdata <= bus.ad_in;
            end
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    assign bus.ad_out = r_ad_out;
    assign bus.ad_oe  = r_ad_oe;
    assign bus.a_d    = r_a_d;
    assign bus.cs     = r_cs;
    assign bus.rd     = r_rd;
    assign bus.wr     = r_wr;
    assign bus.rdata  = r_rdata;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule
